eh2_lsu_dccm_req: RTL and testbench

EH2_LSU_DCCM_REQ -- requirements
Module: eh2_lsu_dccm_req

---
 rtl/eh2_pkg.sv | 35 +++
 rtl/eh2_lsu_stbuf.sv | 84 ++++++++
 rtl/eh2_lsu_dccm_req.sv | 152 +++++++++++++++
 tb/tb_eh2_lsu_dccm_req.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// Shared LSU types: store-buffer depth, access-size encoding, core geometry
// parameters and the size-to-last-byte offset helper.
package eh2_pkg;

    localparam int unsigned STBUF_DEPTH = 4;

    typedef enum logic [1:0] {
        LSU_SIZE_BYTE = 2'd0,
        LSU_SIZE_HALF = 2'd1,
        LSU_SIZE_WORD = 2'd2
    } eh2_lsu_size_e;

    typedef struct packed {
        int unsigned DCCM_BITS;
        int unsigned DCCM_FDATA_WIDTH;
        int unsigned LOAD_TO_USE_PLUS1;
    } eh2_param_t;

    localparam eh2_param_t EH2_PARAM_DEFAULT = '{
        DCCM_BITS:         32'd16,
        DCCM_FDATA_WIDTH:  32'd39,
        LOAD_TO_USE_PLUS1: 32'd0
    };

    // Offset from the first to the last byte of an access; the reserved size 3 acts as a word.
    function automatic logic [1:0] size_offset(input logic [1:0] size);
        case (size)
            LSU_SIZE_BYTE: size_offset = 2'd0;
            LSU_SIZE_HALF: size_offset = 2'd1;
            LSU_SIZE_WORD: size_offset = 2'd3;
            default:       size_offset = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/eh2_lsu_stbuf.sv
// Four-entry circular store buffer; also exposes per-entry valid bits and
// lo/hi word addresses so the load path can detect address overlap.
module eh2_lsu_stbuf
    import eh2_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 39
) (
    input  logic                               clk,
    input  logic                               rst_l,
    input  logic                               push,
    input  logic                               pop,
    input  logic [AW-1:0]                      push_addr,
    input  logic [1:0]                         push_size,
    input  logic [DW-1:0]                      push_lo,
    input  logic [DW-1:0]                      push_hi,
    output logic [2:0]                         count,
    output logic [AW-1:0]                      head_addr,
    output logic [1:0]                         head_size,
    output logic [DW-1:0]                      head_lo,
    output logic [DW-1:0]                      head_hi,
    output logic [STBUF_DEPTH-1:0]             ent_valid,
    output logic [STBUF_DEPTH-1:0][AW-1:2]     ent_lo_word,
    output logic [STBUF_DEPTH-1:0][AW-1:2]     ent_hi_word
);

    logic [1:0]    wr_ptr_r;
    logic [1:0]    rd_ptr_r;
    logic [2:0]    count_r;
    logic [AW-1:0] addr_r [STBUF_DEPTH];
    logic [1:0]    size_r [STBUF_DEPTH];
    logic [DW-1:0] lo_r   [STBUF_DEPTH];
    logic [DW-1:0] hi_r   [STBUF_DEPTH];

    // Pointer and occupancy update; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + 2'd1;
            if (pop)  rd_ptr_r <= rd_ptr_r + 2'd1;
            case ({push, pop})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < STBUF_DEPTH; i++) begin
                addr_r[i] <= '0;
                size_r[i] <= 2'd0;
                lo_r[i]   <= '0;
                hi_r[i]   <= '0;
            end
        end else if (push) begin
            addr_r[wr_ptr_r] <= push_addr;
            size_r[wr_ptr_r] <= push_size;
            lo_r[wr_ptr_r]   <= push_lo;
            hi_r[wr_ptr_r]   <= push_hi;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    for (genvar g = 0; g < STBUF_DEPTH; g++) begin : g_ent
        logic [AW-1:0] hi_addr_s;
        assign hi_addr_s      = addr_r[g] + {{(AW-2){1'b0}}, size_offset(size_r[g])};
        assign ent_lo_word[g] = addr_r[g][AW-1:2];
        assign ent_hi_word[g] = hi_addr_s[AW-1:2];
        assign ent_valid[g]   = (3'(2'(g) - rd_ptr_r) < count_r);
    end

    assign count     = count_r;
    assign head_addr = addr_r[rd_ptr_r];
    assign head_size = size_r[rd_ptr_r];
    assign head_lo   = lo_r[rd_ptr_r];
    assign head_hi   = hi_r[rd_ptr_r];

endmodule

// File: rtl/eh2_lsu_dccm_req.sv
// DCCM request arbiter: loads issue immediately unless they overlap a buffered
// store; buffered stores drain one per load-idle cycle; responses return after L cycles.
module eh2_lsu_dccm_req
    import eh2_pkg::*;
#(
    parameter eh2_param_t pt = EH2_PARAM_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic [pt.DCCM_BITS-1:0]          ld_addr,
    input  logic [1:0]                       ld_size,
    input  logic                             st_valid,
    output logic                             st_ready,
    input  logic [pt.DCCM_BITS-1:0]          st_addr,
    input  logic [1:0]                       st_size,
    input  logic [pt.DCCM_FDATA_WIDTH-1:0]   st_data_lo,
    input  logic [pt.DCCM_FDATA_WIDTH-1:0]   st_data_hi,
    output logic                             dccm_wren,
    output logic                             dccm_rden,
    output logic [pt.DCCM_BITS-1:0]          dccm_wr_addr_lo,
    output logic [pt.DCCM_BITS-1:0]          dccm_wr_addr_hi,
    output logic [pt.DCCM_BITS-1:0]          dccm_rd_addr_lo,
    output logic [pt.DCCM_BITS-1:0]          dccm_rd_addr_hi,
    output logic [pt.DCCM_FDATA_WIDTH-1:0]   dccm_wr_data_lo,
    output logic [pt.DCCM_FDATA_WIDTH-1:0]   dccm_wr_data_hi,
    input  logic [pt.DCCM_FDATA_WIDTH-1:0]   dccm_rd_data_lo,
    input  logic [pt.DCCM_FDATA_WIDTH-1:0]   dccm_rd_data_hi,
    output logic                             ld_resp_valid,
    output logic [pt.DCCM_FDATA_WIDTH-1:0]   ld_resp_data_lo,
    output logic [pt.DCCM_FDATA_WIDTH-1:0]   ld_resp_data_hi,
    output logic                             stbuf_empty
);

    localparam int DB = pt.DCCM_BITS;
    localparam int FW = pt.DCCM_FDATA_WIDTH;
    localparam int L  = 1 + pt.LOAD_TO_USE_PLUS1;

    logic [2:0]                         count_s;
    logic [DB-1:0]                      head_addr_s;
    logic [1:0]                         head_size_s;
    logic [FW-1:0]                      head_lo_s;
    logic [FW-1:0]                      head_hi_s;
    logic [STBUF_DEPTH-1:0]             ent_valid_s;
    logic [STBUF_DEPTH-1:0][DB-1:2]     ent_lo_word_s;
    logic [STBUF_DEPTH-1:0][DB-1:2]     ent_hi_word_s;
    logic [DB-1:0]                      ld_hi_addr_s;
    logic [DB-1:0]                      head_hi_addr_s;
    logic                               hazard_s;
    logic                               ld_fire_s;
    logic                               st_push_s;
    logic                               drain_s;
    logic [DB-1:0]                      rd_addr_lo_r;
    logic [DB-1:0]                      rd_addr_hi_r;
    logic [DB-1:0]                      wr_addr_lo_r;
    logic [DB-1:0]                      wr_addr_hi_r;
    logic [FW-1:0]                      wr_data_lo_r;
    logic [FW-1:0]                      wr_data_hi_r;
    logic [L-1:0]                       resp_sr_r;

    eh2_lsu_stbuf #(.AW(DB), .DW(FW)) u_stbuf (
        .clk         (clk),
        .rst_l       (rst_l),
        .push        (st_push_s),
        .pop         (drain_s),
        .push_addr   (st_addr),
        .push_size   (st_size),
        .push_lo     (st_data_lo),
        .push_hi     (st_data_hi),
        .count       (count_s),
        .head_addr   (head_addr_s),
        .head_size   (head_size_s),
        .head_lo     (head_lo_s),
        .head_hi     (head_hi_s),
        .ent_valid   (ent_valid_s),
        .ent_lo_word (ent_lo_word_s),
        .ent_hi_word (ent_hi_word_s)
    );

    assign ld_hi_addr_s   = ld_addr + {{(DB-2){1'b0}}, size_offset(ld_size)};
    assign head_hi_addr_s = head_addr_s + {{(DB-2){1'b0}}, size_offset(head_size_s)};

    // Any overlap of either end of the load with either end of a live store blocks the load.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < STBUF_DEPTH; i++) begin
            if (ent_valid_s[i] &&
                ((ent_lo_word_s[i] == ld_addr[DB-1:2])      ||
                 (ent_lo_word_s[i] == ld_hi_addr_s[DB-1:2]) ||
                 (ent_hi_word_s[i] == ld_addr[DB-1:2])      ||
                 (ent_hi_word_s[i] == ld_hi_addr_s[DB-1:2]))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    assign ld_ready    = ~hazard_s;
    assign st_ready    = (count_s < 3'd4);
    assign ld_fire_s   = ld_valid & ld_ready;
    assign st_push_s   = st_valid & st_ready;
    assign drain_s     = ~ld_fire_s & (count_s != 3'd0);
    assign stbuf_empty = (count_s == 3'd0);
    assign dccm_rden   = ld_fire_s;
    assign dccm_wren   = drain_s;

    // Last-issued addresses and data, so idle outputs keep their previous value.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_addr_lo_r <= '0;
            rd_addr_hi_r <= '0;
            wr_addr_lo_r <= '0;
            wr_addr_hi_r <= '0;
            wr_data_lo_r <= '0;
            wr_data_hi_r <= '0;
        end else begin
            if (ld_fire_s) begin
                rd_addr_lo_r <= ld_addr;
                rd_addr_hi_r <= ld_hi_addr_s;
            end
            if (drain_s) begin
                wr_addr_lo_r <= head_addr_s;
                wr_addr_hi_r <= head_hi_addr_s;
                wr_data_lo_r <= head_lo_s;
                wr_data_hi_r <= head_hi_s;
            end
        end
    end

    assign dccm_rd_addr_lo = ld_fire_s ? ld_addr        : rd_addr_lo_r;
    assign dccm_rd_addr_hi = ld_fire_s ? ld_hi_addr_s   : rd_addr_hi_r;
    assign dccm_wr_addr_lo = drain_s   ? head_addr_s    : wr_addr_lo_r;
    assign dccm_wr_addr_hi = drain_s   ? head_hi_addr_s : wr_addr_hi_r;
    assign dccm_wr_data_lo = drain_s   ? head_lo_s      : wr_data_lo_r;
    assign dccm_wr_data_hi = drain_s   ? head_hi_s      : wr_data_hi_r;

    // Read-valid pipeline; the truncated concatenation shifts in the new issue at bit 0.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            resp_sr_r <= '0;
        end else begin
            resp_sr_r <= L'({resp_sr_r, ld_fire_s});
        end
    end

    assign ld_resp_valid   = resp_sr_r[L-1];
    assign ld_resp_data_lo = dccm_rd_data_lo;
    assign ld_resp_data_hi = dccm_rd_data_hi;

endmodule

// File: tb/tb_eh2_lsu_dccm_req.sv
// Directed bench: two instances (load-to-use latency 1 and 2) share one stimulus stream.
module tb_eh2_lsu_dccm_req;
    import eh2_pkg::*;

    localparam eh2_param_t P1 = '{DCCM_BITS: 32'd16, DCCM_FDATA_WIDTH: 32'd39, LOAD_TO_USE_PLUS1: 32'd0};
    localparam eh2_param_t P2 = '{DCCM_BITS: 32'd16, DCCM_FDATA_WIDTH: 32'd39, LOAD_TO_USE_PLUS1: 32'd1};

    logic        clk;
    logic        rst_l;
    logic        ld_valid, st_valid;
    logic [15:0] ld_addr, st_addr;
    logic [1:0]  ld_size, st_size;
    logic [38:0] st_data_lo, st_data_hi, rd_data_lo, rd_data_hi;

    logic        ld_ready_a, st_ready_a, wren_a, rden_a, rv_a, empty_a;
    logic [15:0] wr_lo_a, wr_hi_a, rd_lo_a, rd_hi_a;
    logic [38:0] wd_lo_a, wd_hi_a, rdat_lo_a, rdat_hi_a;
    logic        ld_ready_b, st_ready_b, wren_b, rden_b, rv_b, empty_b;
    logic [15:0] wr_lo_b, wr_hi_b, rd_lo_b, rd_hi_b;
    logic [38:0] wd_lo_b, wd_hi_b, rdat_lo_b, rdat_hi_b;

    int checks = 0;
    int errors = 0;

    eh2_lsu_dccm_req #(.pt(P1)) dut_a (
        .clk(clk), .rst_l(rst_l),
        .ld_valid(ld_valid), .ld_ready(ld_ready_a), .ld_addr(ld_addr), .ld_size(ld_size),
        .st_valid(st_valid), .st_ready(st_ready_a), .st_addr(st_addr), .st_size(st_size),
        .st_data_lo(st_data_lo), .st_data_hi(st_data_hi),
        .dccm_wren(wren_a), .dccm_rden(rden_a),
        .dccm_wr_addr_lo(wr_lo_a), .dccm_wr_addr_hi(wr_hi_a),
        .dccm_rd_addr_lo(rd_lo_a), .dccm_rd_addr_hi(rd_hi_a),
        .dccm_wr_data_lo(wd_lo_a), .dccm_wr_data_hi(wd_hi_a),
        .dccm_rd_data_lo(rd_data_lo), .dccm_rd_data_hi(rd_data_hi),
        .ld_resp_valid(rv_a), .ld_resp_data_lo(rdat_lo_a), .ld_resp_data_hi(rdat_hi_a),
        .stbuf_empty(empty_a)
    );

    eh2_lsu_dccm_req #(.pt(P2)) dut_b (
        .clk(clk), .rst_l(rst_l),
        .ld_valid(ld_valid), .ld_ready(ld_ready_b), .ld_addr(ld_addr), .ld_size(ld_size),
        .st_valid(st_valid), .st_ready(st_ready_b), .st_addr(st_addr), .st_size(st_size),
        .st_data_lo(st_data_lo), .st_data_hi(st_data_hi),
        .dccm_wren(wren_b), .dccm_rden(rden_b),
        .dccm_wr_addr_lo(wr_lo_b), .dccm_wr_addr_hi(wr_hi_b),
        .dccm_rd_addr_lo(rd_lo_b), .dccm_rd_addr_hi(rd_hi_b),
        .dccm_wr_data_lo(wd_lo_b), .dccm_wr_data_hi(wd_hi_b),
        .dccm_rd_data_lo(rd_data_lo), .dccm_rd_data_hi(rd_data_hi),
        .ld_resp_valid(rv_b), .ld_resp_data_lo(rdat_lo_b), .ld_resp_data_hi(rdat_hi_b),
        .stbuf_empty(empty_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_l = 1'b0;
        ld_valid = 1'b0; ld_addr = 16'h0; ld_size = 2'd0;
        st_valid = 1'b0; st_addr = 16'h0; st_size = 2'd0;
        st_data_lo = 39'h0; st_data_hi = 39'h0;
        rd_data_lo = 39'h1234567; rd_data_hi = 39'h0ABCDEF;

        mid();
        chk("rst_wren", wren_a, 1'b0);
        chk("rst_rden", rden_a, 1'b0);
        chk("rst_rv_a", rv_a, 1'b0);
        chk("rst_rv_b", rv_b, 1'b0);
        chk("rst_st_ready", st_ready_a, 1'b1);
        chk("rst_ld_ready", ld_ready_a, 1'b1);
        chk("rst_empty", empty_b, 1'b1);
        chk("rst_rd_lo", rd_lo_a, 16'h0);
        chk("rst_wr_lo", wr_lo_a, 16'h0);
        chk("rst_wd_lo", wd_lo_a, 39'h0);
        step(); step();
        rst_l = 1'b1;
        step();

        // load word at 0x100
        ld_valid = 1'b1; ld_addr = 16'h0100; ld_size = 2'd2;
        mid();
        chk("ld_rden", rden_a, 1'b1);
        chk("ld_rd_lo", rd_lo_a, 16'h0100);
        chk("ld_rd_hi", rd_hi_a, 16'h0103);
        chk("ld_no_wren", wren_a, 1'b0);
        step();
        ld_valid = 1'b0;
        mid();
        chk("ld_rden_off", rden_a, 1'b0);
        chk("ld_rv_a_l1", rv_a, 1'b1);
        chk("ld_rv_b_l1", rv_b, 1'b0);
        chk("ld_rdat_lo", rdat_lo_a, 39'h1234567);
        chk("ld_rd_hold", rd_lo_a, 16'h0100);
        step();
        mid();
        chk("ld_rv_a_l2", rv_a, 1'b0);
        chk("ld_rv_b_l2", rv_b, 1'b1);
        chk("ld_rdat_hi", rdat_hi_b, 39'h0ABCDEF);
        step();

        // size 3 acts as word and wraps past the top of the address space
        ld_valid = 1'b1; ld_addr = 16'hFFFE; ld_size = 2'd3;
        mid();
        chk("wrap_rd_hi", rd_hi_a, 16'h0001);
        step();
        ld_valid = 1'b0;
        step(); step();

        // store half at 0x0FF
        st_valid = 1'b1; st_addr = 16'h00FF; st_size = 2'd1;
        st_data_lo = 39'h0AA; st_data_hi = 39'h0BB;
        mid();
        chk("sh_wren_early", wren_a, 1'b0);
        chk("sh_st_ready", st_ready_a, 1'b1);
        step();
        st_valid = 1'b0;
        mid();
        chk("sh_wren", wren_a, 1'b1);
        chk("sh_rden", rden_a, 1'b0);
        chk("sh_wr_lo", wr_lo_a, 16'h00FF);
        chk("sh_wr_hi", wr_hi_a, 16'h0100);
        chk("sh_wd_lo", wd_lo_a, 39'h0AA);
        chk("sh_wd_hi", wd_hi_a, 39'h0BB);
        chk("sh_empty", empty_a, 1'b0);
        step();
        mid();
        chk("sh_wren_off", wren_a, 1'b0);
        chk("sh_empty_after", empty_a, 1'b1);
        chk("sh_wr_hold", wr_lo_a, 16'h00FF);
        step();

        // fill the buffer while loads occupy the bank every cycle
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1; ld_addr = 16'h0400; ld_size = 2'd2;
            st_valid = 1'b1; st_addr = 16'h0010 + 16'(4 * k); st_size = 2'd2;
            st_data_lo = 39'(k + 1); st_data_hi = 39'(16'h0100 + k + 1);
            mid();
            chk("fill_st_ready", st_ready_a, 1'b1);
            chk("fill_rden", rden_a, 1'b1);
            chk("fill_wren", wren_a, 1'b0);
            step();
        end
        st_addr = 16'h0020; st_data_lo = 39'd5;
        mid();
        chk("full_st_ready", st_ready_a, 1'b0);
        chk("full_wren", wren_a, 1'b0);
        step();
        for (int j = 0; j < 5; j++) begin
            ld_valid = 1'b0;
            st_valid = (j < 2);
            mid();
            chk("drain_wren", wren_a, 1'b1);
            chk("drain_rden", rden_a, 1'b0);
            chk("drain_wr_lo", wr_lo_a, 16'h0010 + 16'(4 * j));
            chk("drain_wd_lo", wd_lo_a, 39'(j + 1));
            if (j == 0) chk("drain_full_ready", st_ready_a, 1'b0);
            else if (j == 1) chk("drain_freed_ready", st_ready_a, 1'b1);
            step();
        end
        mid();
        chk("drain_done_wren", wren_a, 1'b0);
        chk("drain_done_empty", empty_a, 1'b1);
        step();

        // load overlapping a buffered store word
        st_valid = 1'b1; st_addr = 16'h0200; st_size = 2'd2; st_data_lo = 39'h55;
        step();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 16'h0202; ld_size = 2'd0;
        mid();
        chk("haz_ld_ready", ld_ready_a, 1'b0);
        chk("haz_rden", rden_a, 1'b0);
        chk("haz_wren", wren_a, 1'b1);
        chk("haz_wr_lo", wr_lo_a, 16'h0200);
        step();
        mid();
        chk("haz_empty", empty_a, 1'b1);
        chk("haz_clear_ready", ld_ready_a, 1'b1);
        chk("haz_issue", rden_a, 1'b1);
        chk("haz_rd_lo", rd_lo_a, 16'h0202);
        step();

        // overlap through the store's upper word only
        ld_valid = 1'b0;
        st_valid = 1'b1; st_addr = 16'h03FF; st_size = 2'd1;
        step();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 16'h0401; ld_size = 2'd0;
        mid();
        chk("hazhi_ld_ready", ld_ready_a, 1'b0);
        chk("hazhi_wr_hi", wr_hi_a, 16'h0400);
        step();
        mid();
        chk("hazhi_issue", rden_a, 1'b1);
        step();
        ld_valid = 1'b0;
        step(); step();

        // loads and stores offered together for eight cycles
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1; ld_addr = 16'h0500 + 16'(4 * i); ld_size = 2'd2;
            st_valid = 1'b1; st_addr = 16'h0600 + 16'(4 * i); st_size = 2'd2;
            st_data_lo = 39'(16'h0600 + i);
            mid();
            chk("mix_rden_a", rden_a, 1'b1);
            chk("mix_rden_b", rden_b, 1'b1);
            chk("mix_wren", wren_a, 1'b0);
            chk("mix_st_ready", st_ready_a, (i < 4));
            chk("mix_rv_a", rv_a, (i >= 1));
            chk("mix_rv_b", rv_b, (i >= 2));
            step();
        end
        for (int j = 0; j < 4; j++) begin
            ld_valid = 1'b0; st_valid = 1'b0;
            mid();
            chk("mixd_wren", wren_a, 1'b1);
            chk("mixd_rden", rden_a, 1'b0);
            chk("mixd_wr_lo", wr_lo_a, 16'h0600 + 16'(4 * j));
            chk("mixd_wd_lo", wd_lo_a, 39'(16'h0600 + j));
            chk("mixd_rv_a", rv_a, (j < 1));
            chk("mixd_rv_b", rv_b, (j < 2));
            step();
        end
        mid();
        chk("mixd_empty", empty_a, 1'b1);
        step();

        // reset with stores buffered and reads in flight
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_addr = 16'h0700; ld_size = 2'd2;
            st_valid = 1'b1; st_addr = 16'h0800 + 16'(4 * k); st_size = 2'd2;
            step();
        end
        ld_valid = 1'b0; st_valid = 1'b0;
        rst_l = 1'b0;
        #1;
        chk("mrst_empty", empty_a, 1'b1);
        chk("mrst_wren", wren_a, 1'b0);
        chk("mrst_rv_a", rv_a, 1'b0);
        chk("mrst_rv_b", rv_b, 1'b0);
        step();
        rst_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("post_wren", wren_a, 1'b0);
            chk("post_rv_a", rv_a, 1'b0);
            chk("post_rv_b", rv_b, 1'b0);
            chk("post_empty", empty_b, 1'b1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
